// File: rtl/dtree_seq_ctrl.sv
// Sequential decision-tree classifier: loads NFEAT signed feature bytes, then walks
// a 16-entry node table one node per cycle through a single shared comparator.
module dtree_seq_ctrl #(
  parameter int NFEAT = 7,
  parameter int NNODE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [19:0] cfg_wdata,
  output logic        cfg_ready,
  input  logic        feat_valid,
  input  logic [7:0]  feat_data,
  output logic        feat_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_class,
  output logic        out_err
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VW = $clog2(NNODE + 1);
  localparam logic [2:0]    LAST_SLOT = 3'(NFEAT - 1);
  localparam logic [3:0]    NFEAT_W   = 4'(NFEAT);
  localparam logic [4:0]    NNODE_W   = 5'(NNODE);
  localparam logic [VW-1:0] VISIT_LIM = VW'(NNODE - 1);

  state_t          state_r, state_s;
  logic [2:0]      fcnt_r;
  logic [3:0]      node_r;
  logic [VW-1:0]   visit_r;
  logic [7:0]      feat_r [0:7];
  logic [19:0]     tbl_r  [0:15];
  logic [4:0]      class_r;
  logic            err_r;

  logic [19:0]     node_word_s;
  logic            is_leaf_s;
  logic [2:0]      fsel_s;
  logic            le_s;
  logic [3:0]      child_s;
  logic            feat_acc_s;
  logic            last_feat_s;
  logic            bad_sel_s;
  logic            loop_lim_s;
  logic            advance_s;
  logic            cap_s;
  logic [4:0]      cap_class_s;
  logic            cap_err_s;

  assign node_word_s = tbl_r[node_r];
  assign is_leaf_s   = node_word_s[19];
  assign fsel_s      = node_word_s[18:16];
  assign le_s        = $signed(feat_r[fsel_s]) <= $signed(node_word_s[15:8]);
  assign child_s     = le_s ? node_word_s[7:4] : node_word_s[3:0];
  assign feat_acc_s  = (state_r == LOAD) && feat_valid;
  assign last_feat_s = feat_acc_s && (fcnt_r == LAST_SLOT);
  assign bad_sel_s   = {1'b0, fsel_s} >= NFEAT_W;
  // The NNODE-th internal visit is the one that trips the loop guard.
  assign loop_lim_s  = (visit_r == VISIT_LIM);

  assign cfg_ready  = (state_r == LOAD) && (fcnt_r == 3'd0);
  assign feat_ready = (state_r == LOAD);
  assign out_valid  = (state_r == DONE);
  assign out_class  = class_r;
  assign out_err    = err_r;

  // Next-state decode and per-node evaluation outcome.
  always_comb begin
    state_s     = state_r;
    advance_s   = 1'b0;
    cap_s       = 1'b0;
    cap_class_s = 5'd0;
    cap_err_s   = 1'b0;
    case (state_r)
      LOAD: begin
        if (last_feat_s) state_s = EVAL;
        else             state_s = LOAD;
      end
      EVAL: begin
        if (is_leaf_s) begin
          cap_s       = 1'b1;
          cap_class_s = node_word_s[4:0];
          state_s     = DONE;
        end else if (bad_sel_s || loop_lim_s) begin
          cap_s     = 1'b1;
          cap_err_s = 1'b1;
          state_s   = DONE;
        end else begin
          advance_s = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_s = LOAD;
        else           state_s = DONE;
      end
      default: state_s = LOAD;
    endcase
  end

  // State, traversal counters and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LOAD;
      fcnt_r  <= 3'd0;
      node_r  <= 4'd0;
      visit_r <= '0;
      class_r <= 5'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (last_feat_s) begin
        fcnt_r  <= 3'd0;
        node_r  <= 4'd0;
        visit_r <= '0;
      end else if (feat_acc_s) begin
        fcnt_r <= fcnt_r + 3'd1;
      end else if (advance_s) begin
        node_r  <= child_s;
        visit_r <= visit_r + 1'b1;
      end
      if (cap_s) begin
        class_r <= cap_class_s;
        err_r   <= cap_err_s;
      end
    end
  end

  // Feature slots and node table storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)  feat_r[i] <= 8'd0;
      for (int i = 0; i < 16; i++) tbl_r[i]  <= 20'h80000;
    end else begin
      if (feat_acc_s) feat_r[fcnt_r] <= feat_data;
      if (cfg_we && cfg_ready && ({1'b0, cfg_addr} < NNODE_W)) tbl_r[cfg_addr] <= cfg_wdata;
    end
  end

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Scoreboard bench for dtree_seq_ctrl: stimulus pushes expected results, a monitor
// checks class, error flag, latency and stability whenever out_valid is high.
module tb_dtree_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = 4'd0;
  logic [19:0] cfg_wdata = 20'd0;
  logic        cfg_ready;
  logic        feat_valid = 1'b0;
  logic [7:0]  feat_data = 8'd0;
  logic        feat_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_class;
  logic        out_err;

  typedef struct {
    logic [4:0] cls;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  dtree_seq_ctrl #(.NFEAT(7), .NNODE(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(feat_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [19:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // fv holds slot i in bits [8*i+7 : 8*i].
  task automatic send_sample(input logic [55:0] fv, input logic [4:0] cls,
                             input logic err, input int lat, input bit push);
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      feat_valid = 1'b1;
      feat_data  = fv[i*8 +: 8];
      @(posedge clk); #1;
    end
    feat_valid = 1'b0;
    if (push) begin
      e.cls = cls; e.err = err; e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic take_result(input int hold, input bit poke_cfg);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_miss++;
      $display("FAIL result_timeout: out_valid never rose within 100 cycles");
    end else begin
      for (int i = 0; i < hold; i++) begin
        if (poke_cfg && i == 1) begin
          cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 20'h80009;
        end else begin
          cfg_we = 1'b0;
        end
        @(negedge clk);
      end
      cfg_we = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  // Monitor: pop on each new result, then hold every valid cycle to that expectation.
  initial begin
    exp_t cur;
    bit   active = 1'b0;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          if (q.size() == 0) begin
            have = 1'b0;
            n_vec++; n_miss++;
            $display("FAIL unexpected_result: out_valid=1 with no expected entry, class %0d err %0d", out_class, out_err);
          end else begin
            have = 1'b1;
            cur = q.pop_front();
            chk("latency", cyc - cur.acc + 1, cur.lat);
          end
        end
        if (have) begin
          chk("out_class", {27'd0, out_class}, {27'd0, cur.cls});
          chk("out_err", {31'd0, out_err}, {31'd0, cur.err});
          chk("feat_ready_in_done", {31'd0, feat_ready}, 32'd0);
        end
      end
    end
  end

  localparam logic [55:0] FV_BASE = 56'h00_77_66_55_44_33_22;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_class", {27'd0, out_class}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_feat_ready", {31'd0, feat_ready}, 32'd1);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    // Unprogrammed table: node 0 is leaf 0.
    send_sample(56'h00_66_55_44_33_22_11, 5'd0, 1'b0, 2, 1'b1);
    take_result(0, 1'b0);

    cfg_write(4'd0, 20'h6FF12);
    cfg_write(4'd1, 20'h80005);
    cfg_write(4'd2, 20'h80019);
    send_sample({8'h80, FV_BASE[47:0]}, 5'd5, 1'b0, 3, 1'b1);
    take_result(0, 1'b0);
    send_sample({8'hFF, FV_BASE[47:0]}, 5'd5, 1'b0, 3, 1'b1);
    take_result(0, 1'b0);
    send_sample({8'h00, FV_BASE[47:0]}, 5'd25, 1'b0, 3, 1'b1);
    take_result(0, 1'b0);
    send_sample({8'h7F, FV_BASE[47:0]}, 5'd25, 1'b0, 3, 1'b1);
    take_result(0, 1'b0);

    // Backpressure with a config write attempted while the result waits.
    send_sample({8'h80, FV_BASE[47:0]}, 5'd5, 1'b0, 3, 1'b1);
    take_result(5, 1'b1);
    send_sample({8'h80, FV_BASE[47:0]}, 5'd5, 1'b0, 3, 1'b1);
    take_result(0, 1'b0);

    // Three-level path: node2 tests slot 0 against +10.
    cfg_write(4'd2, 20'h00A34);
    cfg_write(4'd3, 20'h80007);
    cfg_write(4'd4, 20'h80009);
    send_sample({8'h00, 40'h66_55_44_33_22, 8'h0A}, 5'd7, 1'b0, 4, 1'b1);
    take_result(0, 1'b0);
    send_sample({8'h00, 40'h66_55_44_33_22, 8'h0B}, 5'd9, 1'b0, 4, 1'b1);
    take_result(0, 1'b0);

    // Illegal feature select 7.
    cfg_write(4'd0, 20'h70012);
    send_sample(FV_BASE, 5'd0, 1'b1, 2, 1'b1);
    take_result(0, 1'b0);
    cfg_write(4'd0, 20'h6FF12);
    send_sample({8'h80, FV_BASE[47:0]}, 5'd5, 1'b0, 3, 1'b1);
    take_result(0, 1'b0);

    // Self-loop on node 0.
    cfg_write(4'd0, 20'h00000);
    send_sample(FV_BASE, 5'd0, 1'b1, 17, 1'b1);
    take_result(2, 1'b0);

    // Reset one cycle into EVAL of a looping sample.
    send_sample(FV_BASE, 5'd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_eval_feat_ready", {31'd0, feat_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_eval_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send_sample({8'h80, FV_BASE[47:0]}, 5'd0, 1'b0, 2, 1'b1);
    take_result(0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
